// File: rtl/vec_mac.sv
// rtl/vec_mac.sv - pipelined multi-lane multiply-accumulate (vector dot product) engine
//
// Runs a dot-product job of len beats. Each beat multiplies LANES operand
// pairs, sums the lane products and adds the sum into a wide accumulator.
// The datapath is four stages: operand register, lane products, lane sum,
// accumulate.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clr             synchronous abort: empties the pipeline, zeroes acc/ovf, back to IDLE
//   start, len      job start pulse and beat count (len==0 finishes at once with result 0)
//   signed_mode     1 = two's-complement operands (latched at start)
//   in_valid/ready  operand beat handshake; in_ready only while accumulating
//   a_vec, b_vec    lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/ready result handshake; result held until taken
//   result          accumulated dot product
//   ovf             sticky overflow flag for the current job
//
// Optional feature: define VEC_MAC_SAT_EN to saturate the accumulator on
// overflow and raise ovf. Without it the accumulator wraps and ovf is 0.

module vec_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        signed_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a_vec,
  input  logic [LANES*DATA_WIDTH-1:0] b_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        result,
  output logic                        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [LEN_WIDTH-1:0]        cnt;
  logic                        mode;
  logic                        beat_acc;
  logic                        job_start;

  // Stage 1: registered operands
  logic [LANES*DATA_WIDTH-1:0] a_s1;
  logic [LANES*DATA_WIDTH-1:0] b_s1;
  logic                        v1;
  // Stage 2: registered lane products
  logic [2*DATA_WIDTH-1:0]     prod_c  [LANES];
  logic [2*DATA_WIDTH-1:0]     prod_s2 [LANES];
  logic                        v2;
  // Stage 3: registered lane sum, already extended to accumulator width
  logic [ACC_WIDTH-1:0]        lane_sum;
  logic [ACC_WIDTH-1:0]        sum_s3;
  logic                        v3;
  // Accumulator
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH-1:0]        acc_nxt;

  assign beat_acc  = in_valid && in_ready;
  assign job_start = (state == IDLE) && start;

  // Operands are extended to 2*DATA_WIDTH before multiplying; the low
  // 2*DATA_WIDTH bits of that product are correct for both signed and
  // unsigned operands, and a DATA_WIDTH x DATA_WIDTH product always fits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0]   a_l;
    logic [DATA_WIDTH-1:0]   b_l;
    logic [2*DATA_WIDTH-1:0] a_x;
    logic [2*DATA_WIDTH-1:0] b_x;
    assign a_l       = a_s1[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_l       = b_s1[i*DATA_WIDTH +: DATA_WIDTH];
    assign a_x       = {{DATA_WIDTH{mode & a_l[DATA_WIDTH-1]}}, a_l};
    assign b_x       = {{DATA_WIDTH{mode & b_l[DATA_WIDTH-1]}}, b_l};
    assign prod_c[i] = a_x * b_x;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode) begin
        lane_sum = lane_sum + ACC_WIDTH'($signed(prod_s2[i]));
      end else begin
        lane_sum = lane_sum + ACC_WIDTH'(prod_s2[i]);
      end
    end
  end

`ifdef VEC_MAC_SAT_EN
  logic [ACC_WIDTH:0] add_w;
  logic               sat_hit;
  logic               ovf_q;

  always_comb begin
    add_w   = {1'b0, acc} + {1'b0, sum_s3};
    acc_nxt = add_w[ACC_WIDTH-1:0];
    sat_hit = 1'b0;
    if (mode) begin
      // Signed overflow: both addends share a sign that the sum does not.
      if ((acc[ACC_WIDTH-1] == sum_s3[ACC_WIDTH-1]) &&
          (add_w[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
        sat_hit = 1'b1;
        acc_nxt = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (add_w[ACC_WIDTH]) begin
      sat_hit = 1'b1;
      acc_nxt = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (clr || job_start) begin
      ovf_q <= 1'b0;
    end else if (v3 && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign acc_nxt = acc + sum_s3;
  assign ovf     = 1'b0;
`endif

  // Datapath, valid bits, beat counter and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1   <= '0;
      b_s1   <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      sum_s3 <= '0;
      acc    <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_s2[i] <= '0;
      end
    end else if (clr) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else begin
      v1 <= beat_acc;
      v2 <= v1;
      v3 <= v2;
      if (beat_acc) begin
        a_s1 <= a_vec;
        b_s1 <= b_vec;
        cnt  <= cnt - 1'b1;
      end
      if (v1) begin
        for (int i = 0; i < LANES; i++) begin
          prod_s2[i] <= prod_c[i];
        end
      end
      if (v2) begin
        sum_s3 <= lane_sum;
      end
      // The pipeline is empty in IDLE, so a new job never races a
      // pending accumulate.
      if (job_start) begin
        acc  <= '0;
        cnt  <= len;
        mode <= signed_mode;
      end else if (v3) begin
        acc <= acc_nxt;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (beat_acc && (cnt == LEN_WIDTH'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!v1 && !v2 && !v3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    result    = '0;
    case (state)
      ACCUM: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        result    = acc;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/vec_mac.md
VEC_MAC -- requirements
Module: vec_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand width per lane.
REQ-002 Parameter LANES, default 4: number of parallel multiply lanes, at least 1.
REQ-003 Parameter ACC_WIDTH, default 24: accumulator and result width, at least 2*DATA_WIDTH+clog2(LANES).
REQ-004 Parameter LEN_WIDTH, default 8: width of the beat-count input.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 clr  in  1  synchronous abort/clear.
REQ-008 start  in  1  single-cycle job start.
REQ-009 len  in  LEN_WIDTH  job length in beats; sampled with start.
REQ-010 signed_mode  in  1  1 selects two's-complement operands; sampled with start.
REQ-011 in_valid  in  1  operand beat valid.
REQ-012 in_ready  out  1  block accepts a beat.
REQ-013 a_vec, b_vec  in  LANES*DATA_WIDTH each  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer takes the result.
REQ-016 result  out  ACC_WIDTH  accumulated dot product.
REQ-017 ovf  out  1  sticky overflow flag for the current job.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-019 IDLE: start with len!=0 SHALL go to ACCUM, clear the accumulator and ovf, and load the remaining-beat count with len; start with len==0 SHALL go directly to DONE with result 0.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in ACCUM; a beat is accepted on a cycle where in_valid and in_ready are both 1.
REQ-022 Each accepted beat SHALL decrement the remaining count; acceptance of the final beat SHALL move the FSM to DRAIN.
REQ-023 The pipeline SHALL be: edge T registers operands; edge T+1 registers the LANES products (2*DATA_WIDTH each); edge T+2 registers the lane sum (sign- or zero-extended); edge T+3 adds that sum into the accumulator.
REQ-024 A valid bit SHALL travel with each stage; only valid stages update downstream state.
REQ-025 DRAIN SHALL move to DONE once all stage valid bits are 0, so out_valid rises at edge T+4 after the edge that accepted the final beat.
REQ-026 DONE: out_valid=1 and result=accumulator, both held stable until out_ready=1; the handshake SHALL return the FSM to IDLE.
REQ-027 Without saturation, accumulation SHALL wrap modulo 2^ACC_WIDTH.
REQ-028 clr SHALL take priority over start and handshakes: it empties all valid bits, zeroes the accumulator and ovf, and sets the FSM to IDLE on the next edge.
REQ-029 out_valid and in_ready SHALL be 0 in the cycle after clr.

Reset
REQ-030 Asserting rst SHALL immediately force the FSM to IDLE and set to 0 all pipeline registers, valid bits, the count, the accumulator, ovf, result, out_valid and in_ready, including in the middle of a job.
REQ-031 The first edge after rst deasserts SHALL behave as in IDLE.

Configuration
REQ-032 With macro VEC_MAC_SAT_EN defined, an accumulate that overflows SHALL clamp the accumulator to its maximum or minimum value (unsigned, or signed per signed_mode) and set ovf, which stays set until the next start, clr or rst.
REQ-033 With VEC_MAC_SAT_EN undefined, accumulation SHALL wrap and ovf SHALL be tied to 0.

Verification
REQ-034 Unsigned dot product: LANES=4, len=2, a={1,2,3,4}, b={5,6,7,8} on both beats, in_valid held -> result=140, out_valid 4 cycles after the second beat is accepted.
REQ-035 Signed and backpressure: signed_mode=1, len=1, a=-1 in all lanes, b=2; out_ready held low for 5 cycles -> result=0xFFFFF8 held stable, in_ready=0 throughout, then returns to IDLE on the handshake.
REQ-036 Bubbles and ignored start: len=3 with in_valid toggling every cycle and start pulsed during ACCUM -> exactly 3 beats accumulated, second start ignored.
REQ-037 Abort: clr asserted after 1 of 4 beats -> IDLE next cycle, accumulator 0, no out_valid; a new job with len=1 and a=b={1,1,1,1} -> result=4.
REQ-038 Overflow: unsigned, a=b=255 in all lanes, len=65 -> with VEC_MAC_SAT_EN result=0xFFFFFF and ovf=1; without it result=129284 and ovf=0.
REQ-039 Reset and zero length: rst asserted in DRAIN -> all outputs 0 immediately; start with len=0 -> result=0 and out_valid on the next cycle.
